mobo_dev_bridge: RTL and testbench

//   Motherboard-side bridge from one CPU access to one of n_dev memory-mapped peripherals
//   (VGA is device 0), using a registered four-phase req/ack handshake.

---
 rtl/mobo_dev_bridge.sv | 198 +++++++++++++++++++
 tb/tb_mobo_dev_bridge.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mobo_dev_bridge.sv
// mobo_dev_bridge: CPU-side bridge to n_dev memory-mapped peripherals using a registered
// four-phase req/ack handshake, with device decode, per-state timeout and error pulses.
module mobo_dev_bridge #(
    parameter int word_width     = 32,
    parameter int n_dev          = 2,
    parameter int sel_w          = 1,
    parameter int timeout_cycles = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          is_write,
    input  logic [word_width-1:0]         transl_addr,
    input  logic [word_width-1:0]         cpu_data_out,
    output logic [word_width-1:0]         cpu_data_in,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [n_dev-1:0]              dev_req,
    output logic                          dev_we,
    output logic [word_width-1:0]         addr,
    output logic [word_width-1:0]         data_out,
    input  logic [n_dev-1:0]              dev_ack,
    input  logic [n_dev*word_width-1:0]   dev_data_in
);

    localparam int CNT_W     = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    localparam int TO_LAST_I = (timeout_cycles > 0) ? timeout_cycles - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FREE,
        S_WAIT_ACK,
        S_WAIT_REL,
        S_DONE,
        S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [sel_w-1:0]       idx_q, idx_d;
    logic                   we_q, we_d;
    logic [word_width-1:0]  addr_q, addr_d;
    logic [word_width-1:0]  wdata_q, wdata_d;
    logic [word_width-1:0]  rdata_q, rdata_d;
    logic [n_dev-1:0]       req_q, req_d;
    logic                   dev_we_q, dev_we_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;

    logic [sel_w-1:0]       new_idx;
    logic                   new_bad;
    logic [n_dev-1:0]       sel_oh;
    logic [word_width-1:0]  rd_sel;
    logic                   ack_sel;
    logic                   timed_out;
    logic                   go_err;

    assign new_idx   = transl_addr[word_width-1 -: sel_w];
    assign new_bad   = (32'(new_idx) >= 32'(n_dev));
    assign ack_sel   = |(dev_ack & sel_oh);
    assign timed_out = (timeout_cycles != 0) && (cnt_q == TO_LAST);

    // Decode of the latched device index: request one-hot and read-data mux.
    always_comb begin
        sel_oh = '0;
        rd_sel = '0;
        for (int k = 0; k < n_dev; k++) begin
            sel_oh[k] = (32'(idx_q) == 32'(k));
            if (sel_oh[k]) begin
                rd_sel = dev_data_in[k*word_width +: word_width];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        req_d    = req_q;
        dev_we_d = dev_we_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        go_err   = 1'b0;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = new_idx;
                    we_d    = is_write;
                    addr_d  = transl_addr;
                    wdata_d = cpu_data_out;
                    if (new_bad) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        if (!is_write) rdata_d = '1;
                    end else begin
                        state_d = S_WAIT_FREE;
                    end
                end
            end
            S_WAIT_FREE: begin
                if (!ack_sel) begin
                    req_d    = sel_oh;
                    dev_we_d = we_q;
                    state_d  = S_WAIT_ACK;
                end else if (timed_out) begin
                    go_err = 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (ack_sel) begin
                    if (!we_q) rdata_d = rd_sel;
                    req_d    = '0;
                    dev_we_d = 1'b0;
                    state_d  = S_WAIT_REL;
                end else if (timed_out) begin
                    go_err = 1'b1;
                end
            end
            S_WAIT_REL: begin
                if (!ack_sel) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (timed_out) begin
                    go_err = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A completed handshake on the same cycle always beats the timeout.
        if (go_err) begin
            state_d  = S_ERR;
            err_d    = 1'b1;
            req_d    = '0;
            dev_we_d = 1'b0;
            if (!we_q) rdata_d = '1;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == S_WAIT_FREE || state_q == S_WAIT_ACK || state_q == S_WAIT_REL)
                     && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            req_q    <= '0;
            dev_we_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            req_q    <= req_d;
            dev_we_q <= dev_we_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign cpu_data_in = rdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign dev_req     = req_q;
    assign dev_we      = dev_we_q;
    assign addr        = addr_q;
    assign data_out    = wdata_q;

endmodule

// File: tb/tb_mobo_dev_bridge.sv
// Bench for mobo_dev_bridge: directed handshake scenarios plus randomized traffic checked
// every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mobo_dev_bridge;

    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, is_write;
    logic [31:0] transl_addr, cpu_data_out;
    logic [31:0] cpu_data_in, addr, data_out;
    logic        busy, done, err, dev_we;
    logic [1:0]  dev_req, dev_ack;
    logic [63:0] dev_data_in;

    logic        b_start, b_is_write;
    logic [31:0] b_transl_addr, b_cpu_data_out;
    logic [31:0] b_cpu_data_in, b_addr, b_data_out;
    logic        b_busy, b_done, b_err, b_dev_we;
    logic [0:0]  b_dev_req, b_dev_ack;
    logic [31:0] b_dev_data_in;

    mobo_dev_bridge #(.word_width(32), .n_dev(2), .sel_w(1), .timeout_cycles(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .is_write(is_write),
        .transl_addr(transl_addr), .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
        .busy(busy), .done(done), .err(err), .dev_req(dev_req), .dev_we(dev_we),
        .addr(addr), .data_out(data_out), .dev_ack(dev_ack), .dev_data_in(dev_data_in)
    );

    mobo_dev_bridge #(.word_width(32), .n_dev(1), .sel_w(1), .timeout_cycles(0)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .is_write(b_is_write),
        .transl_addr(b_transl_addr), .cpu_data_out(b_cpu_data_out), .cpu_data_in(b_cpu_data_in),
        .busy(b_busy), .done(b_done), .err(b_err), .dev_req(b_dev_req), .dev_we(b_dev_we),
        .addr(b_addr), .data_out(b_data_out), .dev_ack(b_dev_ack), .dev_data_in(b_dev_data_in)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    bit auto_resp = 1'b0;
    bit noise = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs, walked transaction by transaction.
    logic [31:0] e_rdata, e_addr, e_dout;
    logic [1:0]  e_req;
    logic        e_we, e_busy, e_done, e_err;

    task automatic m_reset();
        e_rdata = '0; e_addr = '0; e_dout = '0; e_req = '0;
        e_we = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
    endtask

    task automatic m_edge(output bit r);
        @(posedge clk);
        r = (rst === 1'b1);
        if (r) m_reset();
    endtask

    // res: 0 = ack reached wanted level, 1 = timed out, 2 = reset
    task automatic wait_phase(input bit ix, input logic want, output int res);
        int n;
        bit r;
        n = 0;
        forever begin
            m_edge(r);
            if (r) begin res = 2; return; end
            if (dev_ack[ix] === want) begin res = 0; return; end
            if (TO != 0 && n == TO - 1) begin res = 1; return; end
            n++;
        end
    endtask

    task automatic m_err(input bit wr);
        bit r;
        e_err = 1'b1; e_req = '0; e_we = 1'b0;
        if (!wr) e_rdata = '1;
        m_edge(r);
        if (!r) begin e_err = 1'b0; e_busy = 1'b0; end
    endtask

    initial begin : model
        bit r, ix, wr;
        int res;
        m_reset();
        forever begin
            m_edge(r);
            if (r || start !== 1'b1) continue;
            wr = is_write;
            ix = transl_addr[31];
            e_addr = transl_addr; e_dout = cpu_data_out; e_busy = 1'b1;
            wait_phase(ix, 1'b0, res);
            if (res == 2) continue;
            if (res == 1) begin m_err(wr); continue; end
            e_req = ix ? 2'b10 : 2'b01;
            e_we  = wr;
            wait_phase(ix, 1'b1, res);
            if (res == 2) continue;
            if (res == 1) begin m_err(wr); continue; end
            e_req = '0; e_we = 1'b0;
            if (!wr) e_rdata = ix ? dev_data_in[63:32] : dev_data_in[31:0];
            wait_phase(ix, 1'b0, res);
            if (res == 2) continue;
            if (res == 1) begin m_err(wr); continue; end
            e_done = 1'b1;
            m_edge(r);
            if (!r) begin e_done = 1'b0; e_busy = 1'b0; end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("m_busy",  32'(busy),    32'(e_busy));
                check("m_done",  32'(done),    32'(e_done));
                check("m_err",   32'(err),     32'(e_err));
                check("m_req",   32'(dev_req), 32'(e_req));
                check("m_we",    32'(dev_we),  32'(e_we));
                check("m_addr",  addr,         e_addr);
                check("m_dout",  data_out,     e_dout);
                check("m_rdata", cpu_data_in,  e_rdata);
            end
        end
    end

    // Randomized peripherals: variable ack latency, variable release, spurious acks.
    initial begin : responder
        int lat [2];
        int hold [2];
        lat = '{0, 0};
        hold = '{0, 0};
        forever begin
            @(posedge clk); #1;
            if (auto_resp) begin
                for (int k = 0; k < 2; k++) begin
                    if (dev_req[k] && !dev_ack[k]) begin
                        if (lat[k] == 0) begin
                            dev_ack[k] = 1'b1;
                            hold[k] = ($urandom_range(0, 15) == 0) ? 10 : int'($urandom_range(0, 3));
                            lat[k]  = int'($urandom_range(0, 11));
                        end else begin
                            lat[k]--;
                        end
                    end else if (!dev_req[k] && dev_ack[k]) begin
                        if (hold[k] == 0) dev_ack[k] = 1'b0;
                        else hold[k]--;
                    end else if (!dev_req[k] && noise && $urandom_range(0, 24) == 0) begin
                        dev_ack[k] = 1'b1;
                        hold[k] = int'($urandom_range(0, 4));
                    end
                    if (!dev_ack[k]) dev_data_in[k*32 +: 32] = $urandom;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic go(input logic w, input logic [31:0] a, input logic [31:0] d);
        start = 1'b1; is_write = w; transl_addr = a; cpu_data_out = d;
        step();
        start = 1'b0;
    endtask

    initial begin : main
        rst = 1'b1; start = 1'b0; is_write = 1'b0; transl_addr = '0; cpu_data_out = '0;
        dev_ack = '0; dev_data_in = '0;
        b_start = 1'b0; b_is_write = 1'b0; b_transl_addr = '0; b_cpu_data_out = '0;
        b_dev_ack = '0; b_dev_data_in = '0;
        step(); step();
        check("rst_req",   32'(dev_req), 32'h0);
        check("rst_busy",  32'(busy),    32'h0);
        check("rst_rdata", cpu_data_in,  32'h0);
        check("rst_addr",  addr,         32'h0);
        check("rst_b_err", 32'(b_err),   32'h0);
        rst = 1'b0;
        chk_en = 1'b1;
        step();

        // Idle ack, device answering in one cycle: done four cycles after start.
        dev_data_in[31:0] = 32'hCAFE_0001;
        go(1'b0, 32'h0000_0020, 32'h0);
        step();
        check("lat_req2", 32'(dev_req), 32'h1);
        dev_ack = 2'b01;
        step();
        check("lat_req3",  32'(dev_req), 32'h0);
        check("lat_done3", 32'(done),    32'h0);
        dev_ack = 2'b00;
        step();
        check("lat_done4", 32'(done),   32'h1);
        check("lat_rdata", cpu_data_in, 32'hCAFE_0001);
        step();
        check("lat_done5", 32'(done), 32'h0);

        // Write to device 0, ack after three waiting cycles.
        go(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        step();
        for (int i = 0; i < 3; i++) begin
            check("wr_req",  32'(dev_req), 32'h1);
            check("wr_we",   32'(dev_we),  32'h1);
            check("wr_addr", addr,         32'h0000_0010);
            check("wr_data", data_out,     32'hDEAD_BEEF);
            step();
        end
        dev_ack = 2'b01;
        step();
        check("wr_req_low", 32'(dev_req), 32'h0);
        dev_ack = 2'b00;
        step();
        check("wr_done", 32'(done), 32'h1);
        check("wr_err",  32'(err),  32'h0);
        step();
        check("wr_done_once", 32'(done), 32'h0);

        // Read from device 1.
        dev_data_in = {32'h1234_5678, 32'hAAAA_5555};
        go(1'b0, 32'h8000_0004, 32'h0);
        step();
        check("rd1_req", 32'(dev_req), 32'h2);
        dev_ack = 2'b10;
        step();
        dev_ack = 2'b00;
        step();
        check("rd1_done",  32'(done),   32'h1);
        check("rd1_rdata", cpu_data_in, 32'h1234_5678);
        step();

        // Ack never rises: eight WAIT_ACK cycles, then error.
        go(1'b1, 32'h0000_0040, 32'h0000_1111);
        step();
        for (int i = 0; i < 8; i++) begin
            check("to_req_held", 32'(dev_req), 32'h1);
            step();
        end
        check("to_err",   32'(err),     32'h1);
        check("to_req0",  32'(dev_req), 32'h0);
        step();
        check("to_err_once", 32'(err),  32'h0);
        check("to_idle",     32'(busy), 32'h0);
        go(1'b1, 32'h0000_0050, 32'h0000_2222);
        step();
        check("to_next_req", 32'(dev_req), 32'h1);
        dev_ack = 2'b01;
        step();
        dev_ack = 2'b00;
        step();
        check("to_next_done", 32'(done), 32'h1);
        step();

        // Stuck ack at start holds in WAIT_FREE.
        dev_ack = 2'b01;
        go(1'b1, 32'h0000_0060, 32'h0000_3333);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stuck_noreq", 32'(dev_req), 32'h0);
            check("stuck_busy",  32'(busy),    32'h1);
        end
        dev_ack = 2'b00;
        step();
        check("stuck_req", 32'(dev_req), 32'h1);
        dev_ack = 2'b01;
        step();
        dev_ack = 2'b00;
        step();
        check("stuck_done", 32'(done), 32'h1);
        step();

        // Start while busy is ignored; reset in WAIT_ACK.
        go(1'b1, 32'h0000_0070, 32'h0000_4444);
        step();
        start = 1'b1; is_write = 1'b0; transl_addr = 32'h8000_0000;
        step();
        start = 1'b0;
        check("busy_addr", addr,         32'h0000_0070);
        check("busy_req",  32'(dev_req), 32'h1);
        rst = 1'b1;
        step();
        check("mrst_req",   32'(dev_req), 32'h0);
        check("mrst_busy",  32'(busy),    32'h0);
        check("mrst_we",    32'(dev_we),  32'h0);
        check("mrst_addr",  addr,         32'h0);
        check("mrst_dout",  data_out,     32'h0);
        check("mrst_rdata", cpu_data_in,  32'h0);
        rst = 1'b0;
        step();

        // Single-device instance: good read, then bad index write and read.
        b_dev_data_in = 32'h1357_9BDF;
        b_start = 1'b1; b_is_write = 1'b0; b_transl_addr = 32'h0000_0100;
        step();
        b_start = 1'b0;
        step();
        check("b_req", 32'(b_dev_req), 32'h1);
        b_dev_ack = 1'b1;
        step();
        b_dev_ack = 1'b0;
        step();
        check("b_done",  32'(b_done),   32'h1);
        check("b_rdata", b_cpu_data_in, 32'h1357_9BDF);
        step();
        b_start = 1'b1; b_is_write = 1'b1; b_transl_addr = 32'h8000_0000;
        step();
        b_start = 1'b0;
        check("b_wbad_err",   32'(b_err),     32'h1);
        check("b_wbad_req",   32'(b_dev_req), 32'h0);
        check("b_wbad_rdata", b_cpu_data_in,  32'h1357_9BDF);
        step();
        check("b_wbad_err_once", 32'(b_err),  32'h0);
        check("b_wbad_idle",     32'(b_busy), 32'h0);
        b_start = 1'b1; b_is_write = 1'b0; b_transl_addr = 32'h8000_0008;
        step();
        b_start = 1'b0;
        check("b_rbad_err",   32'(b_err),     32'h1);
        check("b_rbad_req",   32'(b_dev_req), 32'h0);
        check("b_rbad_rdata", b_cpu_data_in,  32'hFFFF_FFFF);
        step();
        check("b_rbad_err_once", 32'(b_err), 32'h0);

        // Randomized traffic against the model.
        auto_resp = 1'b1;
        noise = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            start        = ($urandom_range(0, 3) == 0);
            is_write     = 1'($urandom_range(0, 1));
            transl_addr  = $urandom;
            cpu_data_out = $urandom;
            rst          = ($urandom_range(0, 299) == 0);
            step();
        end
        start = 1'b0;
        rst = 1'b0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
